rom_fetch_arbiter: RTL and testbench

//  Shares the byte-wide program ROM between the instruction-fetch port (IF) and a load port (LD) used for read-only constants.

---
 rtl/rom_fetch_arbiter.sv | 89 ++++++++
 tb/tb_rom_fetch_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/rom_fetch_arbiter.sv
// rom_fetch_arbiter: round-robin IF/LD arbiter reading 4-byte little-endian words from a byte-wide ROM
module rom_fetch_arbiter #(
  parameter int ROM_BYTES = 16384
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  output logic        ld_ready,
  output logic        ld_rvalid,
  output logic [31:0] ld_rdata,
  output logic        ld_err,
  output logic [31:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, ERR} state_t;
  state_t      state;
  logic [1:0]  cnt;
  logic [31:0] base;
  logic        port;
  logic        last_ld;
  logic [23:0] lanes;
  logic        grant_if, grant_ld, bad;
  logic [31:0] acc_addr, resp_data;
  always_comb begin
    grant_if  = if_req & (~ld_req | last_ld);
    grant_ld  = ld_req & ~grant_if;
    if_ready  = (state == IDLE) & grant_if;
    ld_ready  = (state == IDLE) & grant_ld;
    acc_addr  = grant_ld ? ld_addr : if_addr;
    bad       = (|acc_addr[1:0]) || (acc_addr > 32'(ROM_BYTES - 4));
    rom_addr  = (state == FETCH) ? base + 32'(cnt) : '0;
    busy      = state != IDLE;
    resp_data = (state == DRAIN) ? {rom_data, lanes} : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      base      <= '0;
      port      <= 1'b0;
      last_ld   <= 1'b1;
      lanes     <= '0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      ld_rvalid <= 1'b0;
      ld_rdata  <= '0;
      ld_err    <= 1'b0;
    end else begin
      if_rvalid <= 1'b0;
      ld_rvalid <= 1'b0;
      case (state)
        IDLE: if (grant_if | grant_ld) begin
          base    <= acc_addr;
          port    <= grant_ld;
          last_ld <= grant_ld;
          cnt     <= '0;
          state   <= bad ? ERR : FETCH;
        end
        FETCH: begin
          cnt <= cnt + 2'd1;
          // bytes arrive in order, so shifting in from the top leaves {b2,b1,b0}
          if (cnt != 2'd0) lanes <= {rom_data, lanes[23:8]};
          if (cnt == 2'd3) state <= DRAIN;
        end
        default: begin
          state <= IDLE;
          if (port) begin
            ld_rvalid <= 1'b1;
            ld_rdata  <= resp_data;
            ld_err    <= state == ERR;
          end else begin
            if_rvalid <= 1'b1;
            if_rdata  <= resp_data;
            if_err    <= state == ERR;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// tb_rom_fetch_arbiter: directed checks of arbitration, word assembly, error path and async reset
module tb_rom_fetch_arbiter;
  localparam int ROM_BYTES = 16384;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0, ld_req = 1'b0;
  logic [31:0] if_addr = '0, ld_addr = '0;
  logic        if_ready, if_rvalid, if_err, ld_ready, ld_rvalid, ld_err, busy;
  logic [31:0] if_rdata, ld_rdata, rom_addr;
  logic [7:0]  rom_data = '0;
  logic [7:0]  mem [0:ROM_BYTES-1];
  int total = 0, bad = 0;

  rom_fetch_arbiter #(.ROM_BYTES(ROM_BYTES)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_ready(ld_ready), .ld_rvalid(ld_rvalid),
    .ld_rdata(ld_rdata), .ld_err(ld_err),
    .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= mem[rom_addr[13:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  task automatic do_reset();
    if_req = 1'b0;
    ld_req = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // issue one request at a negedge; lat counts negedges after accept until rvalid
  task automatic xact(input string tag, input logic ld, input logic [31:0] a,
                      output int lat, output logic [31:0] d, output logic e);
    lat = -1;
    d = '0;
    e = 1'b0;
    if (ld) begin ld_req = 1'b1; ld_addr = a; end
    else begin if_req = 1'b1; if_addr = a; end
    #1 chk({tag, "_ready"}, ld ? ld_ready : if_ready, 1);
    @(negedge clk);
    if_req = 1'b0;
    ld_req = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (ld ? ld_rvalid : if_rvalid) begin
        lat = k;
        d = ld ? ld_rdata : if_rdata;
        e = ld ? ld_err : if_err;
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) chk({tag, "_timeout"}, 0, 1);
  endtask

  int lat;
  logic [31:0] d;
  logic e;
  int g_cyc[$], rv_cyc[$];
  logic g_ld[$], rv_ld[$];
  logic [31:0] rv_dat[$];

  initial begin
    for (int i = 0; i < ROM_BYTES; i++) mem[i] = 8'(i * 37 + (i >> 7));
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'hA0; mem[3] = 8'h00;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_if_rvalid", if_rvalid, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_ld_rvalid", ld_rvalid, 0);
    chk("rst_ld_err", ld_err, 0);
    do_reset();

    // word at address 0 with ROM address sequence
    if_req = 1'b1;
    if_addr = 32'h0;
    #1 chk("t1_ready", if_ready, 1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) if_req = 1'b0;
      chk($sformatf("t1_rom_addr%0d", k), rom_addr, k <= 4 ? 32'(k - 1) : 32'h0);
      chk($sformatf("t1_rvalid%0d", k), if_rvalid, k == 6);
    end
    chk("t1_rdata", if_rdata, 32'h00A00513);
    chk("t1_err", if_err, 0);
    chk("t1_idle", busy, 0);

    // simultaneous requests held for four transactions
    do_reset();
    if_req = 1'b1; if_addr = 32'h100;
    ld_req = 1'b1; ld_addr = 32'h200;
    for (int i = 0; i <= 24; i++) begin
      if (i == 24) begin if_req = 1'b0; ld_req = 1'b0; end
      #1;
      if (if_ready) begin g_cyc.push_back(i); g_ld.push_back(1'b0); end
      if (ld_ready) begin g_cyc.push_back(i); g_ld.push_back(1'b1); end
      if (if_rvalid) begin rv_cyc.push_back(i); rv_ld.push_back(1'b0); rv_dat.push_back(if_rdata); end
      if (ld_rvalid) begin rv_cyc.push_back(i); rv_ld.push_back(1'b1); rv_dat.push_back(ld_rdata); end
      @(negedge clk);
    end
    chk("t3_grants", g_cyc.size(), 4);
    chk("t3_resps", rv_cyc.size(), 4);
    for (int j = 0; j < 4; j++) begin
      if (j < g_cyc.size()) begin
        chk($sformatf("t3_g%0d_cyc", j), g_cyc[j], 6 * j);
        chk($sformatf("t3_g%0d_port", j), g_ld[j], j % 2);
      end
      if (j < rv_cyc.size()) begin
        chk($sformatf("t3_r%0d_cyc", j), rv_cyc[j], 6 * j + 6);
        chk($sformatf("t3_r%0d_port", j), rv_ld[j], j % 2);
        chk($sformatf("t3_r%0d_data", j), rv_dat[j], word(j % 2 ? 32'h200 : 32'h100));
      end
    end

    // error paths and last legal word
    xact("t4_mis", 1'b1, 32'h6, lat, d, e);
    chk("t4_mis_lat", lat, 2);
    chk("t4_mis_err", e, 1);
    chk("t4_mis_data", d, 0);
    xact("t4_hi", 1'b1, 32'(ROM_BYTES - 2), lat, d, e);
    chk("t4_hi_err", e, 1);
    xact("t4_last", 1'b1, 32'(ROM_BYTES - 4), lat, d, e);
    chk("t4_last_lat", lat, 6);
    chk("t4_last_err", e, 0);
    chk("t4_last_data", d, word(ROM_BYTES - 4));
    chk("t4_if_hold", if_rdata, word(32'h100));

    // asynchronous reset during FETCH cnt=2
    if_req = 1'b1;
    if_addr = 32'h40;
    @(negedge clk);
    if_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_rom_addr_pre", rom_addr, 32'h42);
    rst_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_rom_addr", rom_addr, 0);
    chk("t5_if_rdata", if_rdata, 0);
    chk("t5_ld_rdata", ld_rdata, 0);
    lat = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      if (if_rvalid || ld_rvalid) lat++;
    end
    chk("t5_no_rvalid", lat, 0);
    xact("t5_after", 1'b0, 32'h80, lat, d, e);
    chk("t5_after_lat", lat, 6);
    chk("t5_after_data", d, word(32'h80));
    chk("t5_after_err", e, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
